// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_ctrl_pkg
// Purpose : Shared constants and types for the pipeline hazard controller.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Writeback select encodings used by the execute stage
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  // Default TPU occupancy after a start reaches execute
  localparam int TPU_LATENCY_DEF = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tpu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : load_use_detect
// Purpose : Flags a decode instruction that reads the destination of a load
//           still in execute. Register 0 never produces a hazard.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] d_op1_reg_i,
  input  logic [4:0] d_op2_reg_i,
  input  logic       d_op1_used_i,
  input  logic       d_op2_used_i,
  input  logic [4:0] x_reg_write_dst_i,
  input  logic       x_reg_write_enable_i,
  input  logic [1:0] x_wb_sel_i,
  output logic       load_use_o
);

  logic w_is_load;
  logic w_op1_hit;
  logic w_op2_hit;

  // A writing load to a non-zero register that either used operand matches
  always_comb begin
    w_is_load  = x_reg_write_enable_i && (x_wb_sel_i == WB_MEM) &&
                 (x_reg_write_dst_i != 5'd0);
    w_op1_hit  = d_op1_used_i && (d_op1_reg_i == x_reg_write_dst_i);
    w_op2_hit  = d_op2_used_i && (d_op2_reg_i == x_reg_write_dst_i);
    load_use_o = w_is_load && (w_op1_hit || w_op2_hit);
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pipe_hazard_ctrl
// Purpose : Stall/flush sequencer for the 5-stage core. Prioritises data
//           cache miss, taken branch, load-use and TPU occupancy, and tracks
//           TPU run time so back-to-back TPU instructions are serialised.
// Config  : PIPE_CTRL_TPU_DONE_HANDSHAKE_EN - TPU run ends on tpu_done_i
//           instead of the fixed TPU_LATENCY counter.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TPU_LATENCY = TPU_LATENCY_DEF,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] d_op1_reg_i,
  input  logic [4:0] d_op2_reg_i,
  input  logic       d_op1_used_i,
  input  logic       d_op2_used_i,
  input  logic       d_tpu_op_i,
  input  logic [4:0] x_reg_write_dst_i,
  input  logic       x_reg_write_enable_i,
  input  logic [1:0] x_wb_sel_i,
  input  logic       x_branch_taken_i,
  input  logic       x_tpu_start_i,
  input  logic       mem_stall_i,
`ifdef PIPE_CTRL_TPU_DONE_HANDSHAKE_EN
  input  logic       tpu_done_i,
`endif
  output logic       stall_f_o,
  output logic       flush_f_o,
  output logic       stall_d_o,
  output logic       flush_d_o,
  output logic       tpu_busy_o,
  output logic       tpu_err_o
);

  tpu_state_t r_state;
  tpu_state_t w_state_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       w_load_use;
  logic       w_busy;

`ifndef PIPE_CTRL_TPU_DONE_HANDSHAKE_EN
  // Counter starts at LATENCY-1 so RUN spans exactly TPU_LATENCY cycles
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(TPU_LATENCY - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  load_use_detect u_load_use_detect (
    .d_op1_reg_i          (d_op1_reg_i),
    .d_op2_reg_i          (d_op2_reg_i),
    .d_op1_used_i         (d_op1_used_i),
    .d_op2_used_i         (d_op2_used_i),
    .x_reg_write_dst_i    (x_reg_write_dst_i),
    .x_reg_write_enable_i (x_reg_write_enable_i),
    .x_wb_sel_i           (x_wb_sel_i),
    .load_use_o           (w_load_use)
  );

`ifdef PIPE_CTRL_TPU_DONE_HANDSHAKE_EN
  // TPU FSM next state: run until the TPU signals completion
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (x_tpu_start_i) w_state_nxt = RUN;
      end
      RUN: begin
        if (tpu_done_i) begin
          // A start on the finishing edge begins a fresh run
          w_state_nxt = x_tpu_start_i ? RUN : IDLE;
        end else if (x_tpu_start_i) begin
          w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // TPU FSM state and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end
`else
  // TPU FSM next state: fixed-latency countdown
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (x_tpu_start_i) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = c_reload;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          // A start on the finishing edge begins a fresh run
          if (x_tpu_start_i) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = c_reload;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (x_tpu_start_i) w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // TPU FSM state, busy counter and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end
`endif

  assign w_busy = (r_state == RUN) && !rst_i;

  // Hazard priority mux: reset, cache miss, branch, load-use, TPU busy
  always_comb begin
    stall_f_o = 1'b0;
    flush_f_o = 1'b0;
    stall_d_o = 1'b0;
    flush_d_o = 1'b0;
    if (rst_i) begin
      flush_f_o = 1'b1;
      flush_d_o = 1'b1;
    end else if (mem_stall_i) begin
      // Execute holds, so a pending branch reasserts once the miss clears
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
    end else if (x_branch_taken_i) begin
      flush_f_o = 1'b1;
      flush_d_o = 1'b1;
    end else if (w_load_use) begin
      stall_f_o = 1'b1;
      flush_d_o = 1'b1;
    end else if (d_tpu_op_i && w_busy) begin
      stall_f_o = 1'b1;
      flush_d_o = 1'b1;
    end
  end

  assign tpu_busy_o = w_busy;
  assign tpu_err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_pipe_hazard_ctrl
// Purpose : Directed self-checking bench for pipe_hazard_ctrl with
//           TPU_LATENCY=4 (handshake variant under
//           PIPE_CTRL_TPU_DONE_HANDSHAKE_EN).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] d_op1_reg, d_op2_reg;
  logic       d_op1_used, d_op2_used, d_tpu_op;
  logic [4:0] x_dst;
  logic       x_we;
  logic [1:0] x_wb_sel;
  logic       x_br, x_tpu_start, mem_stall;
  logic       tpu_done;
  logic       stall_f, flush_f, stall_d, flush_d, tpu_busy, tpu_err;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl #(.TPU_LATENCY(4), .CNT_W(8)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .d_op1_reg_i          (d_op1_reg),
    .d_op2_reg_i          (d_op2_reg),
    .d_op1_used_i         (d_op1_used),
    .d_op2_used_i         (d_op2_used),
    .d_tpu_op_i           (d_tpu_op),
    .x_reg_write_dst_i    (x_dst),
    .x_reg_write_enable_i (x_we),
    .x_wb_sel_i           (x_wb_sel),
    .x_branch_taken_i     (x_br),
    .x_tpu_start_i        (x_tpu_start),
    .mem_stall_i          (mem_stall),
`ifdef PIPE_CTRL_TPU_DONE_HANDSHAKE_EN
    .tpu_done_i           (tpu_done),
`endif
    .stall_f_o            (stall_f),
    .flush_f_o            (flush_f),
    .stall_d_o            (stall_d),
    .flush_d_o            (flush_d),
    .tpu_busy_o           (tpu_busy),
    .tpu_err_o            (tpu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] op1, op2;
    logic       u1, u2, tpu_op;
    logic [4:0] dst;
    logic       we;
    logic [1:0] wb;
    logic       br, mem;
    logic [3:0] exp; // {stall_f, flush_f, stall_d, flush_d}
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    d_op1_reg = 5'd0; d_op2_reg = 5'd0; d_op1_used = 1'b0; d_op2_used = 1'b0;
    d_tpu_op = 1'b0; x_dst = 5'd0; x_we = 1'b0; x_wb_sel = WB_ALU;
    x_br = 1'b0; x_tpu_start = 1'b0; mem_stall = 1'b0; tpu_done = 1'b0;
  endtask

  // Advance into the next cycle; state for that cycle is settled on return
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {stall_f, flush_f, stall_d, flush_d};
  endfunction

  initial begin
    vecs[0]  = '{"idle",          5'd0, 5'd0, 0, 0, 0, 5'd0, 0, WB_ALU, 0, 0, 4'b0000};
    vecs[1]  = '{"lu_op2_r7",     5'd3, 5'd7, 1, 1, 0, 5'd7, 1, WB_MEM, 0, 0, 4'b1001};
    vecs[2]  = '{"lu_r0",         5'd3, 5'd0, 1, 1, 0, 5'd0, 1, WB_MEM, 0, 0, 4'b0000};
    vecs[3]  = '{"lu_op2_unused", 5'd3, 5'd7, 1, 0, 0, 5'd7, 1, WB_MEM, 0, 0, 4'b0000};
    vecs[4]  = '{"lu_alu_wb",     5'd3, 5'd7, 1, 1, 0, 5'd7, 1, WB_ALU, 0, 0, 4'b0000};
    vecs[5]  = '{"lu_op1_r9",     5'd9, 5'd2, 1, 0, 0, 5'd9, 1, WB_MEM, 0, 0, 4'b1001};
    vecs[6]  = '{"lu_no_we",      5'd9, 5'd2, 1, 1, 0, 5'd9, 0, WB_MEM, 0, 0, 4'b0000};
    vecs[7]  = '{"br_over_lu",    5'd3, 5'd7, 1, 1, 0, 5'd7, 1, WB_MEM, 1, 0, 4'b0101};
    vecs[8]  = '{"mem_over_br",   5'd3, 5'd7, 1, 1, 0, 5'd7, 1, WB_MEM, 1, 1, 4'b1010};
    vecs[9]  = '{"mem_only",      5'd0, 5'd0, 0, 0, 0, 5'd0, 0, WB_ALU, 0, 1, 4'b1010};
    vecs[10] = '{"tpu_op_idle",   5'd0, 5'd0, 0, 0, 1, 5'd0, 0, WB_ALU, 0, 0, 4'b0000};

    clear_inputs();
    rst = 1'b1;

    // Reset: flushes forced while held, registered state clean afterwards
    next_cycle(); #2;
    chk("rst_outs", outs(), 4'b0101);
    chk("rst_busy", {3'b0, tpu_busy}, 4'h0);
    next_cycle(); rst = 1'b0; #2;
    chk("post_rst_outs", outs(), 4'b0000);
    chk("post_rst_err", {3'b0, tpu_err}, 4'h0);

    // Combinational priority table, TPU idle
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      clear_inputs();
      d_op1_reg = vecs[i].op1; d_op2_reg = vecs[i].op2;
      d_op1_used = vecs[i].u1; d_op2_used = vecs[i].u2; d_tpu_op = vecs[i].tpu_op;
      x_dst = vecs[i].dst; x_we = vecs[i].we; x_wb_sel = vecs[i].wb;
      x_br = vecs[i].br; mem_stall = vecs[i].mem;
      #2;
      chk(vecs[i].name, outs(), vecs[i].exp);
    end

    // Load-use bubble: load advances next cycle, a bubble sits in execute
    next_cycle(); clear_inputs();
    d_op2_reg = 5'd7; d_op2_used = 1'b1; x_dst = 5'd7; x_we = 1'b1; x_wb_sel = WB_MEM;
    #2; chk("lu_seq_c0", outs(), 4'b1001);
    next_cycle(); x_we = 1'b0; x_dst = 5'd0; x_wb_sel = WB_ALU;
    #2; chk("lu_seq_c1", outs(), 4'b0000);

`ifdef PIPE_CTRL_TPU_DONE_HANDSHAKE_EN
    // Done while idle is ignored
    next_cycle(); clear_inputs(); tpu_done = 1'b1;
    #2; chk("hs_done_idle", {3'b0, tpu_busy}, 4'h0);
    next_cycle(); clear_inputs();
    #2; chk("hs_done_idle_after", {3'b0, tpu_busy}, 4'h0);
    // Start at cycle 0, done at cycle 20: busy 1..20
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1;
    #2; chk("hs_c0_busy", {3'b0, tpu_busy}, 4'h0);
    for (int c = 1; c <= 22; c++) begin
      next_cycle(); clear_inputs();
      tpu_done = (c == 20);
      #2;
      chk($sformatf("hs_busy_c%0d", c), {3'b0, tpu_busy}, {3'b0, (c >= 1 && c <= 20)});
    end
    chk("hs_err", {3'b0, tpu_err}, 4'h0);
`else
    // Latency 4 run with a TPU op from cycle 2 and a cache miss in cycle 3
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1;
    #2; chk("tpu_c0_busy", {3'b0, tpu_busy}, 4'h0);
    for (int c = 1; c <= 6; c++) begin
      next_cycle(); clear_inputs();
      d_tpu_op = (c >= 2);
      mem_stall = (c == 3);
      #2;
      chk($sformatf("tpu_busy_c%0d", c), {3'b0, tpu_busy}, {3'b0, (c <= 4)});
      chk($sformatf("tpu_outs_c%0d", c), outs(),
          {(c >= 2 && c <= 4), 1'b0, (c == 3), (c == 2 || c == 4)});
    end

    // Start on the finishing edge is a fresh run, not an error
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1; #2;
    for (int c = 1; c <= 9; c++) begin
      next_cycle(); clear_inputs();
      x_tpu_start = (c == 4);
      #2;
      chk($sformatf("b2b_busy_c%0d", c), {3'b0, tpu_busy}, {3'b0, (c <= 8)});
    end
    chk("b2b_err", {3'b0, tpu_err}, 4'h0);

    // Start in mid-run: error set and sticky, schedule unchanged
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1; #2;
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); clear_inputs();
      x_tpu_start = (c == 2);
      #2;
      chk($sformatf("dbl_busy_c%0d", c), {3'b0, tpu_busy}, {3'b0, (c <= 4)});
      chk($sformatf("dbl_err_c%0d", c), {3'b0, tpu_err}, {3'b0, (c >= 3)});
    end
`endif

    // Reset in mid-run clears state and the sticky error
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1; #2;
    next_cycle(); clear_inputs(); x_tpu_start = 1'b1; #2;
    next_cycle(); clear_inputs(); #2;
    chk("midrst_busy_pre", {3'b0, tpu_busy}, 4'h1);
    next_cycle(); rst = 1'b1; #2;
    chk("midrst_outs", outs(), 4'b0101);
    chk("midrst_busy", {3'b0, tpu_busy}, 4'h0);
    next_cycle(); rst = 1'b0; d_tpu_op = 1'b1; #2;
    chk("midrst_after_busy", {3'b0, tpu_busy}, 4'h0);
    chk("midrst_after_err", {3'b0, tpu_err}, 4'h0);
    chk("midrst_after_outs", outs(), 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core.
- Drives the IF/ID hold and flush, and the ID/EX stall and flush inputs of the decode stage.
- Resolves four hazard sources: load-use, taken branch, data-cache miss, and TPU occupancy.
- Tracks TPU run time with an internal FSM and counter, so back-to-back TPU instructions are serialised.

Parameters:
- TPU_LATENCY, 16: cycles the TPU is busy after a start reaches execute (legal range 1..255).
- CNT_W, 8: width of the TPU busy counter.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- d_op1_reg_i  in  5  decode source register 1
- d_op2_reg_i  in  5  decode source register 2
- d_op1_used_i  in  1  decode instruction reads op1
- d_op2_used_i  in  1  decode instruction reads op2
- d_tpu_op_i  in  1  decode instruction is a TPU start or TPU A/B/C write
- x_reg_write_dst_i  in  5  execute-stage destination register
- x_reg_write_enable_i  in  1  execute-stage register write enable
- x_wb_sel_i  in  2  execute-stage writeback select; WB_MEM marks a load
- x_branch_taken_i  in  1  branch resolved taken in execute
- x_tpu_start_i  in  1  TPU start in execute, one-cycle pulse
- mem_stall_i  in  1  data cache not ready
- stall_f_o  out  1  hold PC and IF/ID
- flush_f_o  out  1  clear IF/ID
- stall_d_o  out  1  hold ID/EX (decode stall_i)
- flush_d_o  out  1  clear ID/EX controls (decode flush_i)
- tpu_busy_o  out  1  TPU is running
- tpu_err_o  out  1  sticky: start seen while busy

Behaviour:
- Stall/flush outputs are combinational from inputs and registered state. Counter, FSM and tpu_err_o are registered.
- Reset (rst_i=1), takes effect at the clock edge:
  - FSM to IDLE, counter to 0, tpu_err_o to 0.
  - While rst_i is high, outputs are forced: flush_f_o=1, flush_d_o=1, stall_f_o=0, stall_d_o=0, tpu_busy_o=0.
- Priority of the hazard sources, highest first:
  1. mem_stall_i=1: stall_f_o=1, stall_d_o=1, flush_f_o=0, flush_d_o=0. The branch is not acted on (execute holds, so the branch reasserts later). The TPU counter keeps running.
  2. x_branch_taken_i=1: flush_f_o=1, flush_d_o=1, stalls 0. Overrides load-use and TPU hazards, because the younger instructions are discarded.
  3. Load-use:
     - Condition: x_reg_write_enable_i && x_wb_sel_i==WB_MEM && x_reg_write_dst_i!=0 && ((d_op1_used_i && d_op1_reg_i==x_reg_write_dst_i) || (d_op2_used_i && d_op2_reg_i==x_reg_write_dst_i)).
     - Response: stall_f_o=1, flush_d_o=1, one bubble. It self-clears the next cycle as the load advances.
  4. TPU hazard: d_tpu_op_i && tpu_busy_o gives stall_f_o=1, flush_d_o=1 every cycle until busy drops.
  - Otherwise all stall/flush outputs are 0.
- TPU FSM (IDLE, RUN):
  - IDLE to RUN on x_tpu_start_i; counter loads TPU_LATENCY-1.
  - In RUN, the counter decrements each cycle. At 0 it returns to IDLE the following edge.
  - tpu_busy_o = (state==RUN). Busy therefore lasts exactly TPU_LATENCY cycles after the start cycle.
  - x_tpu_start_i while in RUN: ignored (counter not reloaded) and tpu_err_o set. Only rst_i clears tpu_err_o.
  - x_tpu_start_i on the same edge RUN finishes: accepted as a new start (reload, stay in RUN), no error.
- Register 0 never causes a load-use stall.

Optional Feature:
- Macro PIPE_CTRL_TPU_DONE_HANDSHAKE_EN.
- When defined:
  - Adds input tpu_done_i (1 bit).
  - RUN exits to IDLE only on tpu_done_i=1; the counter is unused and TPU_LATENCY is ignored.
  - tpu_done_i in IDLE is ignored.
- When undefined: fixed-latency counter behaviour as above, and no tpu_done_i port.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - WB_MEM = 2'b01, WB_ALU = 2'b00, WB_PC = 2'b10
  - tpu_state_t enum {IDLE, RUN}
  - TPU_LATENCY_DEF
- Sub-module load_use_detect (combinational) computes the load-use condition. The top module holds the FSM, the counter and the priority mux.

Test Plan:
- Reset mid-TPU run (counter=5) -> next cycle: state IDLE, tpu_busy_o=0, tpu_err_o=0. While rst_i=1: flush_f_o=1, flush_d_o=1.
- Load to r7 in execute, decode reads r7 via op2 -> stall_f_o=1, flush_d_o=1 for exactly 1 cycle. Same case with dst r0 -> no stall.
- x_branch_taken_i=1 together with a load-use match -> flush_f_o=1, flush_d_o=1, stall_f_o=0. With mem_stall_i=1 also asserted -> stall_f_o=1, stall_d_o=1, both flushes 0.
- TPU_LATENCY=4, start pulse at cycle 0 -> tpu_busy_o=1 in cycles 1-4, 0 in cycle 5. A d_tpu_op_i held from cycle 2 sees stall_f_o=1 in cycles 2-4 and is released in cycle 5.
- Second x_tpu_start_i at cycle 2 of a run -> tpu_err_o=1 and stays 1; busy still ends on the original schedule.
- With PIPE_CTRL_TPU_DONE_HANDSHAKE_EN: start, then tpu_done_i at cycle 20 -> busy from cycle 1 through 20, low at cycle 21.
